// File: rtl/k16_host_ctrl_if.sv
// Host byte-stream link between the UART/FIFO bridge and the K16 host controller.
// master = host bridge side, slave = controller side.
interface k16_host_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/k16_host_ctrl.sv
// K16 boot/debug controller: loads program memory, peeks/pokes data memory,
// runs the core and reports HALT back to the host over a byte stream.
module k16_host_ctrl #(
    parameter int unsigned HALT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    k16_host_ctrl_if.slave       host,
    output logic                 cpu_rst,
    input  logic [23:0]          cpu_p,
    input  logic [15:0]          cpu_p_addr,
    input  logic [15:0]          cpu_d_addr,
    input  logic [15:0]          cpu_w_data,
    input  logic                 cpu_we,
    output logic [15:0]          pm_addr,
    output logic [23:0]          pm_wdata,
    output logic                 pm_we,
    output logic [15:0]          dm_addr,
    output logic [15:0]          dm_wdata,
    output logic                 dm_we,
    input  logic [15:0]          dm_rdata
);

    localparam int unsigned AW  = 16;
    localparam int unsigned PW  = 24;
    localparam int unsigned DW  = 16;
    localparam int unsigned BW  = 8;
    localparam int unsigned HCW = $clog2(HALT_CYCLES + 1);

    localparam logic [BW-1:0] OP_LOADP  = 8'h01;
    localparam logic [BW-1:0] OP_WRITED = 8'h02;
    localparam logic [BW-1:0] OP_READD  = 8'h03;
    localparam logic [BW-1:0] OP_RUN    = 8'h04;
    localparam logic [BW-1:0] OP_STOP   = 8'h05;
    localparam logic [BW-1:0] RSP_ACK   = 8'h55;
    localparam logic [BW-1:0] RSP_NAK   = 8'hEE;
    localparam logic [BW-1:0] RSP_HALT  = 8'hAA;
    localparam logic [BW-1:0] HALT_OPC  = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE, S_ARG, S_PWR, S_DWR, S_DRD, S_TX, S_RUN
    } state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   op_q, op_d;
    logic [2:0]      idx_q, idx_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   word_q, word_d;
    logic [8:0]      wleft_q, wleft_d;
    logic [BW-1:0]   tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [15:0]     rsp_q, rsp_d;
    logic [1:0]      rsp_n_q, rsp_n_d;
    logic            rx_ready_q, rx_ready_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic [AW-1:0]   pm_addr_q, pm_addr_d;
    logic [PW-1:0]   pm_wdata_q, pm_wdata_d;
    logic            pm_we_q, pm_we_d;
    logic [AW-1:0]   dm_addr_q, dm_addr_d;
    logic [DW-1:0]   dm_wdata_q, dm_wdata_d;
    logic            dm_we_q, dm_we_d;
    logic [HCW-1:0]  hc_q, hc_d;
    logic [AW-1:0]   haddr_q, haddr_d;

    logic            rx_fire, tx_fire, is_run, is_halt_op;
    logic            last_pm_byte, last_dw_byte, last_dr_byte;
    logic [HCW-1:0]  hc_next;
    logic            halt_hit;
    logic            unused_bits;

    assign rx_fire      = host.rx_valid && rx_ready_q;
    assign tx_fire      = tx_valid_q && host.tx_ready;
    assign is_run       = (state_q == S_RUN);
    assign last_pm_byte = (op_q == OP_LOADP)  && (idx_q == 3'd5);
    assign last_dw_byte = (op_q == OP_WRITED) && (idx_q == 3'd3);
    assign last_dr_byte = (op_q == OP_READD)  && (idx_q == 3'd1);
    assign is_halt_op   = (cpu_p[23:16] == HALT_OPC);
    assign unused_bits  = ^cpu_p[15:0];

    // HALT must be seen at one unchanging address; a new address restarts the run at 1.
    always_comb begin
        hc_next = '0;
        if (is_halt_op) begin
            if (hc_q != '0 && cpu_p_addr == haddr_q)
                hc_next = (hc_q == HCW'(HALT_CYCLES)) ? hc_q : hc_q + HCW'(1);
            else
                hc_next = HCW'(1);
        end
    end

    // Halt waits while a reply byte is in flight or a byte is being consumed.
    assign halt_hit = is_run && (hc_next == HCW'(HALT_CYCLES)) && !tx_valid_q && !rx_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rx_fire) begin
                case (host.rx_data)
                    OP_LOADP, OP_WRITED, OP_READD: state_d = S_ARG;
                    OP_RUN:                        state_d = S_RUN;
                    default:                       state_d = S_TX;
                endcase
            end
            S_ARG: if (rx_fire) begin
                if (last_pm_byte)      state_d = S_PWR;
                else if (last_dw_byte) state_d = S_DWR;
                else if (last_dr_byte) state_d = S_DRD;
            end
            S_PWR:   state_d = (wleft_q == 9'd1) ? S_TX : S_ARG;
            S_DWR:   state_d = S_TX;
            S_DRD:   state_d = S_TX;
            S_TX:    if (tx_fire && rsp_n_q == 2'd0) state_d = S_IDLE;
            S_RUN: begin
                if (rx_fire && host.rx_data == OP_STOP) state_d = S_TX;
                else if (halt_hit)                      state_d = S_TX;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        word_d     = word_q;
        wleft_d    = wleft_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        rsp_d      = rsp_q;
        rsp_n_d    = rsp_n_q;
        cpu_rst_d  = cpu_rst_q;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;
        pm_we_d    = 1'b0;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_we_d    = 1'b0;
        hc_d       = '0;
        haddr_d    = haddr_q;

        // Response shifter: next byte goes out the cycle after each handshake.
        if (tx_fire) begin
            if (rsp_n_q != 2'd0) begin
                tx_data_d = rsp_q[15:8];
                rsp_d     = {rsp_q[7:0], 8'h00};
                rsp_n_d   = rsp_n_q - 2'd1;
            end else begin
                tx_valid_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: if (rx_fire) begin
                op_d  = host.rx_data;
                idx_d = 3'd0;
                case (host.rx_data)
                    OP_LOADP, OP_WRITED, OP_READD: ;
                    OP_RUN: cpu_rst_d = 1'b0;
                    OP_STOP: begin
                        cpu_rst_d  = 1'b1;
                        tx_data_d  = RSP_ACK;
                        tx_valid_d = 1'b1;
                        rsp_n_d    = 2'd0;
                    end
                    default: begin
                        tx_data_d  = RSP_NAK;
                        tx_valid_d = 1'b1;
                        rsp_n_d    = 2'd0;
                    end
                endcase
            end
            S_ARG: if (rx_fire) begin
                idx_d = idx_q + 3'd1;
                if (idx_q < 3'd2) addr_d = {addr_q[7:0], host.rx_data};
                else              word_d = {word_q[15:0], host.rx_data};
                if (op_q == OP_LOADP && idx_q == 3'd2)
                    wleft_d = {host.rx_data == 8'h00, host.rx_data};
                if (last_pm_byte) begin
                    pm_we_d    = 1'b1;
                    pm_addr_d  = addr_q;
                    pm_wdata_d = {word_q[15:0], host.rx_data};
                end
                if (last_dw_byte) begin
                    dm_we_d    = 1'b1;
                    dm_addr_d  = addr_q;
                    dm_wdata_d = {word_q[7:0], host.rx_data};
                end
                if (last_dr_byte)
                    dm_addr_d = {addr_q[7:0], host.rx_data};
            end
            S_PWR: begin
                addr_d  = addr_q + 16'd1;
                wleft_d = wleft_q - 9'd1;
                idx_d   = 3'd3;
                if (wleft_q == 9'd1) begin
                    tx_data_d  = RSP_ACK;
                    tx_valid_d = 1'b1;
                    rsp_n_d    = 2'd0;
                end
            end
            S_DWR: begin
                tx_data_d  = RSP_ACK;
                tx_valid_d = 1'b1;
                rsp_n_d    = 2'd0;
            end
            S_DRD: begin
                tx_data_d  = dm_rdata[15:8];
                rsp_d      = {dm_rdata[7:0], 8'h00};
                rsp_n_d    = 2'd1;
                tx_valid_d = 1'b1;
            end
            S_RUN: begin
                hc_d    = hc_next;
                haddr_d = cpu_p_addr;
                if (rx_fire) begin
                    tx_valid_d = 1'b1;
                    rsp_n_d    = 2'd0;
                    if (host.rx_data == OP_STOP) begin
                        cpu_rst_d = 1'b1;
                        tx_data_d = RSP_ACK;
                        hc_d      = '0;
                    end else begin
                        tx_data_d = RSP_NAK;
                    end
                end else if (halt_hit) begin
                    cpu_rst_d  = 1'b1;
                    tx_data_d  = RSP_HALT;
                    rsp_d      = cpu_p_addr;
                    rsp_n_d    = 2'd2;
                    tx_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rx_ready_d = (state_d == S_IDLE) || (state_d == S_ARG) ||
                        ((state_d == S_RUN) && !tx_valid_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            wleft_q    <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            rsp_q      <= '0;
            rsp_n_q    <= '0;
            rx_ready_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
            pm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_we_q    <= 1'b0;
            hc_q       <= '0;
            haddr_q    <= '0;
        end else begin
            op_q       <= op_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            wleft_q    <= wleft_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            rsp_q      <= rsp_d;
            rsp_n_q    <= rsp_n_d;
            rx_ready_q <= rx_ready_d;
            cpu_rst_q  <= cpu_rst_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
            pm_we_q    <= pm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_we_q    <= dm_we_d;
            hc_q       <= hc_d;
            haddr_q    <= haddr_d;
        end
    end

    // While the core runs it owns the data port outright.
    assign dm_addr  = is_run ? cpu_d_addr : dm_addr_q;
    assign dm_wdata = is_run ? cpu_w_data : dm_wdata_q;
    assign dm_we    = is_run ? cpu_we     : dm_we_q;

    assign host.rx_ready = rx_ready_q;
    assign host.tx_data  = tx_data_q;
    assign host.tx_valid = tx_valid_q;
    assign cpu_rst       = cpu_rst_q;
    assign pm_addr       = pm_addr_q;
    assign pm_wdata      = pm_wdata_q;
    assign pm_we         = pm_we_q;

endmodule

// File: tb/tb_k16_host_ctrl.sv
// Directed self-checking bench for k16_host_ctrl: host command sequences against
// a data-memory model and a snooped program bus driven by the bench.
module tb_k16_host_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rst;
    logic [23:0] cpu_p = 24'h0;
    logic [15:0] cpu_p_addr = 16'h0;
    logic [15:0] cpu_d_addr = 16'h0;
    logic [15:0] cpu_w_data = 16'h0;
    logic        cpu_we = 1'b0;
    logic [15:0] pm_addr;
    logic [23:0] pm_wdata;
    logic        pm_we;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_we;

    k16_host_ctrl_if hif ();

    k16_host_ctrl #(.HALT_CYCLES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (hif),
        .cpu_rst    (cpu_rst),
        .cpu_p      (cpu_p),
        .cpu_p_addr (cpu_p_addr),
        .cpu_d_addr (cpu_d_addr),
        .cpu_w_data (cpu_w_data),
        .cpu_we     (cpu_we),
        .pm_addr    (pm_addr),
        .pm_wdata   (pm_wdata),
        .pm_we      (pm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_we      (dm_we),
        .dm_rdata   (dm_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] dmem [0:65535];
    assign dm_rdata = dmem[dm_addr];
    always @(posedge clk) if (dm_we) dmem[dm_addr] <= dm_wdata;

    // Program-memory write log plus count of writes seen while rx_ready was high.
    logic [39:0] pm_log [$];
    int          pm_rdy_hi = 0;
    int          dm_we_cnt = 0;
    always @(negedge clk) begin
        if (pm_we) begin
            pm_log.push_back({pm_addr, pm_wdata});
            if (hif.rx_ready) pm_rdy_hi++;
        end
        if (dm_we && !rst) dm_we_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        hif.rx_data  = b;
        hif.rx_valid = 1'b1;
        while (!hif.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ready_wait", {39'h0, hif.rx_ready}, 40'h1);
        @(posedge clk);
        #1;
        hif.rx_valid = 1'b0;
    endtask

    task automatic get_byte(input string tag, input logic [7:0] exp);
        int n = 0;
        @(negedge clk);
        while (!hif.tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {39'h0, hif.tx_valid}, 40'h1);
        chk(tag, {32'h0, hif.tx_data}, {32'h0, exp});
        hif.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        hif.tx_ready = 1'b0;
    endtask

    task automatic send_word(input logic [23:0] w);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    int          base;
    logic        stall_ok;
    logic [7:0]  first_b;

    initial begin
        hif.rx_data  = 8'h00;
        hif.rx_valid = 1'b0;
        hif.tx_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_cpu_rst",  {39'h0, cpu_rst}, 40'h1);
        chk("rst_rx_ready", {39'h0, hif.rx_ready}, 40'h1);
        chk("rst_tx_valid", {39'h0, hif.tx_valid}, 40'h0);
        chk("rst_tx_data",  {32'h0, hif.tx_data}, 40'h0);
        chk("rst_pm",       {pm_we, pm_addr, pm_wdata}, 41'h0);
        chk("rst_dm",       {dm_we, dm_addr, dm_wdata}, 33'h0);
        rst = 1'b0;
        @(negedge clk);

        // LOADP 0x0010, two words
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h02);
        send_word(24'h200005);
        send_word(24'h010000);
        get_byte("loadp_ack", 8'h55);
        chk("loadp_count", 40'(pm_log.size()), 40'd2);
        chk("loadp_w0", pm_log[0], {16'h0010, 24'h200005});
        chk("loadp_w1", pm_log[1], {16'h0011, 24'h010000});
        chk("loadp_ready_low", 40'(pm_rdy_hi), 40'd0);
        chk("loadp_cpu_rst", {39'h0, cpu_rst}, 40'h1);

        // WRITED then READD
        send_byte(8'h02); send_byte(8'h01); send_byte(8'h00); send_byte(8'hBE); send_byte(8'hEF);
        get_byte("writed_ack", 8'h55);
        chk("writed_pulses", 40'(dm_we_cnt), 40'd1);
        chk("writed_mem", {24'h0, dmem[16'h0100]}, {24'h0, 16'hBEEF});
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
        get_byte("readd_hi", 8'hBE);
        get_byte("readd_lo", 8'hEF);

        // Program ending in HALT at 0x0003, then RUN
        base = pm_log.size();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        send_word(24'h200005); send_word(24'h000000);
        send_word(24'h000000); send_word(24'h010000);
        get_byte("prog_ack", 8'h55);
        chk("prog_last", pm_log[base+3], {16'h0003, 24'h010000});
        cpu_p = 24'h200005;
        cpu_p_addr = 16'h0000;
        send_byte(8'h04);
        chk("run_cpu_rst", {39'h0, cpu_rst}, 40'h0);
        @(negedge clk);
        cpu_d_addr = 16'h1234; cpu_w_data = 16'h5678; cpu_we = 1'b1;
        #1;
        chk("run_pass", {7'h0, dm_we, dm_addr, dm_wdata}, {7'h0, 1'b1, 16'h1234, 16'h5678});
        @(negedge clk);
        cpu_we = 1'b0;
        cpu_p = 24'h010000;
        cpu_p_addr = 16'h0003;
        @(negedge clk);
        chk("halt_c1", {39'h0, hif.tx_valid}, 40'h0);
        @(negedge clk);
        chk("halt_c2", {39'h0, hif.tx_valid}, 40'h0);
        @(negedge clk);
        chk("halt_c3", {38'h0, hif.tx_valid, cpu_rst}, 40'h3);
        get_byte("halt_tag", 8'hAA);
        get_byte("halt_hi", 8'h00);
        get_byte("halt_lo", 8'h03);
        chk("halt_cpu_rst", {39'h0, cpu_rst}, 40'h1);
        chk("halt_idle_ready", {39'h0, hif.rx_ready}, 40'h1);
        chk("halt_dm_owned", {39'h0, dm_we}, 40'h0);

        // Looping core: non-STOP byte rejected, STOP accepted
        cpu_p = 24'h200005;
        cpu_p_addr = 16'h0010;
        send_byte(8'h04);
        send_byte(8'h02);
        chk("run_busy_ready", {39'h0, hif.rx_ready}, 40'h0);
        get_byte("run_nak", 8'hEE);
        chk("run_still", {39'h0, cpu_rst}, 40'h0);
        chk("run_ready_back", {39'h0, hif.rx_ready}, 40'h1);
        send_byte(8'h05);
        chk("stop_cpu_rst", {39'h0, cpu_rst}, 40'h1);
        get_byte("stop_ack", 8'h55);

        // Unknown opcode, then LOADP wrapping the address
        send_byte(8'h7F);
        get_byte("bad_op", 8'hEE);
        chk("bad_op_idle", {39'h0, hif.rx_ready}, 40'h1);
        base = pm_log.size();
        send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        send_word(24'h111111);
        send_word(24'h222222);
        get_byte("wrap_ack", 8'h55);
        chk("wrap_w0", pm_log[base],   {16'hFFFF, 24'h111111});
        chk("wrap_w1", pm_log[base+1], {16'h0000, 24'h222222});

        // READD reply with tx_ready stalled
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
        @(negedge clk);
        while (!hif.tx_valid) @(negedge clk);
        first_b  = hif.tx_data;
        stall_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!hif.tx_valid || hif.tx_data != first_b || hif.rx_ready) stall_ok = 1'b0;
        end
        chk("stall_stable", {39'h0, stall_ok}, 40'h1);
        get_byte("stall_hi", 8'hBE);
        chk("stall_ready_low", {39'h0, hif.rx_ready}, 40'h0);
        get_byte("stall_lo", 8'hEF);
        chk("stall_done", {39'h0, hif.rx_ready}, 40'h1);

        // rst in the middle of a LOADP word
        base = pm_log.size();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h01);
        send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_write", 40'(pm_log.size()), 40'(base));
        chk("abort_ready", {38'h0, hif.rx_ready, cpu_rst}, 40'h3);
        send_byte(8'h7F);
        get_byte("abort_idle", 8'hEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/k16_host_ctrl.md
# k16_host_ctrl

Host-side boot and debug controller for the K16 processor core. It owns the core's reset and the program-memory write port, and shares the data-memory port between the core and a host byte stream. The host uses it to load programs, peek and poke data memory, start execution and detect HALT. It sits between the host link (UART/FIFO bridge) and the processor/memory pair at the top level.

## Interface
Parameters:
- HALT_CYCLES, 3: consecutive cycles with HALT opcode at a stable p_addr that count as halted.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  host command byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- tx_data  out  8  response byte.
- tx_valid  out  1  response valid, held until accepted.
- tx_ready  in  1  host accepts tx_data.
- cpu_rst  out  1  processor reset.
- cpu_p  in  24  instruction word on the processor program bus (snooped).
- cpu_p_addr  in  16  processor program address.
- cpu_d_addr, cpu_w_data  in  16  processor data address and write data.
- cpu_we  in  1  processor data write enable.
- pm_addr  out  16  program-memory write address.
- pm_wdata  out  24  program-memory write data.
- pm_we  out  1  program-memory write strobe.
- dm_addr, dm_wdata  out  16  data-memory address and write data.
- dm_we  out  1  data-memory write enable.
- dm_rdata  in  16  data-memory read data, asynchronous: valid in the same cycle as dm_addr.

## Operation
- All multi-byte fields are big-endian.
- Commands:
  - 0x01 LOADP: addr16, cnt8 (0 means 256), then cnt × 3-byte words. Each word is written to pm at addr+k. The address wraps mod 2^16.
  - 0x02 WRITED: addr16, data16. Performs one dm write.
  - 0x03 READD: addr16. Returns 2 bytes of dm data.
  - 0x04 RUN: releases cpu_rst.
  - 0x05 STOP: forces cpu_rst.
- Acknowledgements:
  - LOADP, WRITED and STOP reply 0x55 when done.
  - RUN gives no immediate reply.
- States:
  - IDLE: decode the opcode byte.
  - ARG: collect argument bytes with a byte counter.
  - PWR: one-cycle pm write.
  - DWR: one-cycle dm write.
  - DRD: dm read.
  - TX: shift out the response bytes.
  - RUNNING: processor active.
- Error handling:
  - An unknown opcode returns 0xEE and goes back to IDLE.
  - In RUNNING, STOP is the only accepted opcode. Any other byte is consumed and answered 0xEE, and the core keeps running.
- Data-port ownership:
  - In RUNNING, dm_* is a combinational pass-through of cpu_d_addr, cpu_w_data and cpu_we.
  - In all other states the controller drives dm_*, and dm_we is high only in DWR.
- Halt detection, in RUNNING:
  - Halted when cpu_p[23:16]==8'h01 and cpu_p_addr is unchanged for HALT_CYCLES consecutive cycles.
  - Any mismatch clears the counter.
  - On halt: assert cpu_rst and send 0xAA followed by the halt address (hi, lo). Then return to IDLE.
- STOP in RUNNING: cpu_rst asserts the cycle after acceptance. Reply 0x55 and return to IDLE.
- rx_ready is high in IDLE, ARG and RUNNING, except that it is low in RUNNING while a reply is pending. It is low in all other states.

## Timing
- Reset values:
  - cpu_rst=1, state IDLE, rx_ready=1.
  - tx_valid=0, tx_data=0.
  - pm_we=0, pm_addr=0, pm_wdata=0.
  - dm_we=0, dm_addr=0, dm_wdata=0.
  - Halt counter 0.
- rst mid-command aborts the command. No partial pm write occurs after rst.
- LOADP: pm_we pulses for exactly 1 cycle, in the cycle after the 3rd byte of each word is accepted. rx_ready is low in that cycle. After the last word, send 0x55.
- WRITED: dm_we pulses for 1 cycle after the 4th argument byte, then 0x55.
- READD: in DRD, dm_addr is driven and dm_rdata is captured on the same edge. tx_valid rises on the next cycle.
- tx_valid stays high with tx_data stable until tx_ready. The next byte, or the return to IDLE, follows the cycle after the handshake.
- RUN: cpu_rst falls the cycle after the opcode is accepted. The halt counter starts at 0.
- cpu_rst and tx_valid are registered. dm_* in RUNNING is combinational.

## Test plan
- rst pulse, then LOADP 0x0010 cnt=2 with words 0x200005, 0x010000 -> pm_we pulses at 0x0010 (0x200005) and 0x0011 (0x010000), then tx 0x55. cpu_rst stays 1.
- WRITED 0x0100 0xBEEF, then READD 0x0100 (memory model) -> one dm_we pulse, tx 0x55, then tx 0xBE, 0xEF.
- LOADP a program ending in HALT at 0x0003, then RUN -> cpu_rst falls, dm_* follows cpu_*. After HALT_CYCLES, tx 0xAA, 0x00, 0x03 and cpu_rst=1.
- RUN a loop with no HALT, send 0x02 -> tx 0xEE and the core keeps running. Then send STOP -> cpu_rst=1, tx 0x55.
- Opcode 0x7F in IDLE -> tx 0xEE, back in IDLE. LOADP at 0xFFFF with cnt=2 -> writes at 0xFFFF, then at 0x0000.
- tx_ready held low for 10 cycles during a READD reply -> tx_valid and tx_data stay stable, and rx_ready stays 0 until the reply completes.
